// File: rtl/regfile_sb.sv
// Register file with write-back scoreboard and in-order load queue; reads combinational, writes at the edge.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write-backs to the read ports; loads back-pressure via o_ld_ready.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int LQ_DEPTH = 4,
   localparam int AW = $clog2(NREGS),
   localparam int OW = $clog2(XLEN / 8),
   localparam int CW = $clog2(LQ_DEPTH) + 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [AW-1:0]   i_rs1_addr,
   input  logic [AW-1:0]   i_rs2_addr,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic            o_rs1_busy,
   output logic            o_rs2_busy,
   input  logic            i_issue_valid,
   input  logic [AW-1:0]   i_issue_rd,
   input  logic            i_issue_is_load,
   input  logic [2:0]      i_issue_ld_op,
   input  logic [OW-1:0]   i_issue_ld_offset,
   output logic            o_issue_ready,
   input  logic            i_alu_we,
   input  logic [AW-1:0]   i_alu_rd,
   input  logic [XLEN-1:0] i_alu_wdata,
   input  logic            i_ld_valid,
   input  logic [XLEN-1:0] i_ld_data,
   output logic            o_ld_ready,
   output logic [CW-1:0]   o_lq_count
);

   localparam int PW = $clog2(LQ_DEPTH);

   logic [XLEN-1:0] r_regs   [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [AW-1:0]   r_lq_rd  [LQ_DEPTH];
   logic [2:0]      r_lq_op  [LQ_DEPTH];
   logic [OW-1:0]   r_lq_off [LQ_DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;

   logic [AW-1:0]   w_head_rd;
   logic [2:0]      w_head_op;
   logic [OW-1:0]   w_head_off;
   logic            w_lq_empty;
   logic            w_lq_full;
   logic            w_issue_fire;
   logic            w_push;
   logic            w_ld_fire;
   logic [1:0]      w_size;
   logic [OW-1:0]   w_off;
   logic [XLEN-1:0] w_shifted;
   logic            w_sign;
   logic            w_fill;
   int              w_nbits;
   logic [XLEN-1:0] w_ld_result;
   logic [NREGS-1:0] w_busy_nxt;
   logic [AW-1:0]   w_raddr [2];
   logic [XLEN-1:0] w_rdata [2];
   logic            w_rbusy [2];

   assign w_head_rd  = r_lq_rd[r_rptr];
   assign w_head_op  = r_lq_op[r_rptr];
   assign w_head_off = r_lq_off[r_rptr];
   assign w_lq_empty = (r_count == '0);
   assign w_lq_full  = (r_count == CW'(LQ_DEPTH));

   // Only the registered busy bit gates issue, so a same-cycle clear never raises ready.
   assign o_issue_ready = !((i_issue_rd != '0) && r_busy[i_issue_rd]) && !(i_issue_is_load && w_lq_full);
   assign w_issue_fire  = i_issue_valid && o_issue_ready;
   assign w_push        = w_issue_fire && i_issue_is_load;

   // A same-register ALU write takes the array port; the load retries next cycle.
   assign o_ld_ready = !w_lq_empty && !(i_alu_we && (i_alu_rd == w_head_rd) && (w_head_rd != '0));
   assign w_ld_fire  = i_ld_valid && o_ld_ready;
   assign o_lq_count = r_count;

   always_comb begin
      w_size = w_head_op[1:0];
      if (XLEN == 32 && w_size == 2'b11) w_size = 2'b10;
      w_off     = (w_head_off >> w_size) << w_size;
      w_shifted = i_ld_data >> {w_off, 3'b000};
      case (w_size)
         2'b00:   begin w_sign = w_shifted[7];      w_nbits = 8;    end
         2'b01:   begin w_sign = w_shifted[15];     w_nbits = 16;   end
         2'b10:   begin w_sign = w_shifted[31];     w_nbits = 32;   end
         default: begin w_sign = w_shifted[XLEN-1]; w_nbits = XLEN; end
      endcase
      w_fill = !w_head_op[2] && w_sign;
      w_ld_result = '0;
      for (int b = 0; b < XLEN; b++) begin
         w_ld_result[b] = (b < w_nbits) ? w_shifted[b] : w_fill;
      end
   end

   always_comb begin
      w_busy_nxt = r_busy;
      if (i_alu_we) w_busy_nxt[i_alu_rd] = 1'b0;
      if (w_ld_fire) w_busy_nxt[w_head_rd] = 1'b0;
      if (w_issue_fire && (i_issue_rd != '0)) w_busy_nxt[i_issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   assign w_raddr[0] = i_rs1_addr;
   assign w_raddr[1] = i_rs2_addr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rdata[p] = r_regs[w_raddr[p]];
         w_rbusy[p] = r_busy[w_raddr[p]];
`ifdef REGFILE_SB_BYPASS_EN
         if (i_alu_we && (i_alu_rd == w_raddr[p])) begin
            w_rdata[p] = i_alu_wdata;
            w_rbusy[p] = 1'b0;
         end else if (w_ld_fire && (w_head_rd == w_raddr[p])) begin
            w_rdata[p] = w_ld_result;
            w_rbusy[p] = 1'b0;
         end
`endif
         if (w_raddr[p] == '0) begin
            w_rdata[p] = '0;
            w_rbusy[p] = 1'b0;
         end
      end
   end

   assign o_rs1_data = w_rdata[0];
   assign o_rs2_data = w_rdata[1];
   assign o_rs1_busy = w_rbusy[0];
   assign o_rs2_busy = w_rbusy[1];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         for (int i = 0; i < LQ_DEPTH; i++) begin
            r_lq_rd[i]  <= '0;
            r_lq_op[i]  <= '0;
            r_lq_off[i] <= '0;
         end
         r_busy  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_alu_we && (i_alu_rd != '0)) r_regs[i_alu_rd] <= i_alu_wdata;
         if (w_ld_fire && (w_head_rd != '0)) r_regs[w_head_rd] <= w_ld_result;
         r_busy <= w_busy_nxt;
         if (w_push) begin
            r_lq_rd[r_wptr]  <= i_issue_rd;
            r_lq_op[r_wptr]  <= i_issue_ld_op;
            r_lq_off[r_wptr] <= i_issue_ld_offset;
            r_wptr           <= r_wptr + 1'b1;
         end
         if (w_ld_fire) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_ld_fire);
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (XLEN=32, NREGS=32, LQ_DEPTH=4); expected load results queued at issue.
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int LQ_DEPTH = 4;
   localparam int AW = 5;
   localparam int OW = 2;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [AW-1:0]   rs1_addr = '0, rs2_addr = '0;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            rs1_busy, rs2_busy;
   logic            issue_valid = 1'b0;
   logic [AW-1:0]   issue_rd = '0;
   logic            issue_is_load = 1'b0;
   logic [2:0]      issue_ld_op = '0;
   logic [OW-1:0]   issue_ld_offset = '0;
   logic            issue_ready;
   logic            alu_we = 1'b0;
   logic [AW-1:0]   alu_rd = '0;
   logic [XLEN-1:0] alu_wdata = '0;
   logic            ld_valid = 1'b0;
   logic [XLEN-1:0] ld_data = '0;
   logic            ld_ready;
   logic [CW-1:0]   lq_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] exp;
   } sb_t;
   sb_t sb[$];

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .LQ_DEPTH(LQ_DEPTH)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
      .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
      .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .i_issue_is_load(issue_is_load),
      .i_issue_ld_op(issue_ld_op), .i_issue_ld_offset(issue_ld_offset), .o_issue_ready(issue_ready),
      .i_alu_we(alu_we), .i_alu_rd(alu_rd), .i_alu_wdata(alu_wdata),
      .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
      .o_lq_count(lq_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Independent reference for RV32 load formatting.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [1:0] off, input logic [31:0] d);
      logic [31:0] s;
      case (op)
         3'b000: begin s = d >> (8 * off); return {{24{s[7]}}, s[7:0]}; end
         3'b100: begin s = d >> (8 * off); return {24'h0, s[7:0]}; end
         3'b001: begin s = off[1] ? {16'h0, d[31:16]} : d; return {{16{s[15]}}, s[15:0]}; end
         3'b101: begin s = off[1] ? {16'h0, d[31:16]} : d; return {16'h0, s[15:0]}; end
         default: return d;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] rd, input logic is_load, input logic [2:0] op,
                        input logic [OW-1:0] off, output logic ok);
      issue_valid = 1'b1; issue_rd = rd; issue_is_load = is_load;
      issue_ld_op = op; issue_ld_offset = off;
      #1;
      ok = issue_ready;
      step();
      issue_valid = 1'b0; issue_is_load = 1'b0;
   endtask

   task automatic respond(input logic [XLEN-1:0] data, output logic ok);
      ld_valid = 1'b1; ld_data = data; ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (ld_ready) begin
            ok = 1'b1;
            step();
            break;
         end
         step();
      end
      ld_valid = 1'b0;
   endtask

   task automatic test_reset();
      for (int a = 0; a < NREGS; a++) begin
         rs1_addr = AW'(a); rs2_addr = AW'(NREGS - 1 - a);
         #1;
         checks++;
         if ({rs1_data, rs2_data, rs1_busy, rs2_busy} !== '0) begin
            failures++;
            $display("FAIL reset_read addr=%0d got d1=%h d2=%h b1=%b b2=%b want all 0", a, rs1_data, rs2_data, rs1_busy, rs2_busy);
         end
      end
      issue_valid = 1'b1; issue_rd = 5'd1; issue_is_load = 1'b0;
      #1;
      checks++;
      if ({issue_ready, ld_ready, lq_count} !== {1'b1, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL reset_ctrl got issue_ready=%b ld_ready=%b lq_count=%0d want 1 0 0", issue_ready, ld_ready, lq_count);
      end
      issue_valid = 1'b0;
      ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL empty_ld_ready got=%b want 0", ld_ready);
      end
      step();
      ld_valid = 1'b0;
      #1;
      checks++;
      if (lq_count !== 3'd0) begin
         failures++;
         $display("FAIL empty_ld_count got=%0d want 0", lq_count);
      end
   endtask

   task automatic test_lb();
      logic ok;
      sb_t e;
      issue(5'd5, 1'b1, 3'b000, 2'd1, ok);
      sb.push_back('{rd: 5'd5, data: 32'h0000_8000, exp: 32'hFFFF_FF80});
      rs1_addr = 5'd5;
      #1;
      checks++;
      if ({ok, rs1_busy, lq_count} !== {1'b1, 1'b1, 3'd1}) begin
         failures++;
         $display("FAIL lb_issue got ok=%b busy=%b count=%0d want 1 1 1", ok, rs1_busy, lq_count);
      end
      e = sb.pop_front();
      respond(e.data, ok);
      #1;
      checks++;
      if ({ok, rs1_data, rs1_busy, lq_count} !== {1'b1, e.exp, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL lb_retire got ok=%b x5=%h busy=%b count=%0d want 1 %h 0 0", ok, rs1_data, rs1_busy, lq_count, e.exp);
      end
   endtask

   task automatic test_lhu_busy();
      logic ok;
      sb_t e;
      issue(5'd6, 1'b1, 3'b101, 2'd2, ok);
      sb.push_back('{rd: 5'd6, data: 32'hABCD_1234, exp: 32'h0000_ABCD});
      issue_valid = 1'b1; issue_rd = 5'd6; issue_is_load = 1'b0;
      #1;
      checks++;
      if ({ok, issue_ready} !== 2'b10) begin
         failures++;
         $display("FAIL lhu_reissue got ok=%b issue_ready=%b want 1 0", ok, issue_ready);
      end
      step();
      e = sb.pop_front();
      ld_valid = 1'b1; ld_data = e.data;
      #1;
      checks++;
      if ({ld_ready, issue_ready} !== 2'b10) begin
         failures++;
         $display("FAIL lhu_same_cycle got ld_ready=%b issue_ready=%b want 1 0", ld_ready, issue_ready);
      end
      step();
      ld_valid = 1'b0;
      rs2_addr = 5'd6;
      #1;
      checks++;
      if ({issue_ready, rs2_data} !== {1'b1, e.exp}) begin
         failures++;
         $display("FAIL lhu_retire got issue_ready=%b x6=%h want 1 %h", issue_ready, rs2_data, e.exp);
      end
      issue_valid = 1'b0;
   endtask

   task automatic test_fill();
      logic ok;
      sb_t e;
      logic [2:0] ops [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b000};
      logic [1:0] offs [8] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < LQ_DEPTH; k++) begin
            int idx = r * LQ_DEPTH + k;
            logic [31:0] d = $urandom | 32'h8080_8080;
            if (k == 1) d = d & 32'h7F7F_FFFF;
            issue(AW'(10 + idx), 1'b1, ops[idx], offs[idx], ok);
            sb.push_back('{rd: AW'(10 + idx), data: d, exp: model(ops[idx], offs[idx], d)});
            checks++;
            if (ok !== 1'b1) begin
               failures++;
               $display("FAIL fill_issue idx=%0d got ready=%b want 1", idx, ok);
            end
         end
         issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd9;
         #1;
         checks++;
         if ({lq_count, issue_ready} !== {3'd4, 1'b0}) begin
            failures++;
            $display("FAIL fill_full got count=%0d load_ready=%b want 4 0", lq_count, issue_ready);
         end
         issue_is_load = 1'b0;
         #1;
         checks++;
         if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_nonload got issue_ready=%b want 1", issue_ready);
         end
         issue_valid = 1'b0;
         for (int k = 0; k < LQ_DEPTH; k++) begin
            e = sb.pop_front();
            respond(e.data, ok);
            rs1_addr = e.rd;
            #1;
            checks++;
            if ({ok, rs1_data, lq_count} !== {1'b1, e.exp, CW'(LQ_DEPTH - 1 - k)}) begin
               failures++;
               $display("FAIL fill_retire rd=%0d got ok=%b data=%h count=%0d want 1 %h %0d", e.rd, ok, rs1_data, lq_count, e.exp, LQ_DEPTH - 1 - k);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic ok;
      sb_t e;
      issue(5'd20, 1'b1, 3'b010, 2'd0, ok);
      sb.push_back('{rd: 5'd20, data: 32'h1357_9BDF, exp: 32'h1357_9BDF});
      sb.push_back('{rd: 5'd21, data: 32'h0000_C300, exp: 32'h0000_00C3});
      e = sb.pop_front();
      issue_valid = 1'b1; issue_rd = 5'd21; issue_is_load = 1'b1; issue_ld_op = 3'b100; issue_ld_offset = 2'd1;
      ld_valid = 1'b1; ld_data = e.data;
      #1;
      checks++;
      if ({ok, issue_ready, ld_ready} !== 3'b111) begin
         failures++;
         $display("FAIL b2b_ready got ok=%b issue_ready=%b ld_ready=%b want 1 1 1", ok, issue_ready, ld_ready);
      end
      step();
      issue_valid = 1'b0; issue_is_load = 1'b0; ld_valid = 1'b0;
      rs1_addr = 5'd20;
      #1;
      checks++;
      if ({lq_count, rs1_data} !== {3'd1, e.exp}) begin
         failures++;
         $display("FAIL b2b_pushpop got count=%0d x20=%h want 1 %h", lq_count, rs1_data, e.exp);
      end
      e = sb.pop_front();
      respond(e.data, ok);
      rs1_addr = e.rd;
      #1;
      checks++;
      if ({ok, rs1_data, lq_count} !== {1'b1, e.exp, 3'd0}) begin
         failures++;
         $display("FAIL b2b_second got ok=%b x21=%h count=%0d want 1 %h 0", ok, rs1_data, lq_count, e.exp);
      end
      issue(5'd0, 1'b1, 3'b000, 2'd0, ok);
      rs1_addr = 5'd0;
      #1;
      checks++;
      if ({ok, lq_count, rs1_busy} !== {1'b1, 3'd1, 1'b0}) begin
         failures++;
         $display("FAIL x0_load_issue got ok=%b count=%0d busy=%b want 1 1 0", ok, lq_count, rs1_busy);
      end
      respond(32'hFFFF_FFFF, ok);
      #1;
      checks++;
      if ({ok, lq_count, rs1_data} !== {1'b1, 3'd0, 32'h0}) begin
         failures++;
         $display("FAIL x0_load_retire got ok=%b count=%0d x0=%h want 1 0 0", ok, lq_count, rs1_data);
      end
   endtask

   task automatic test_collision();
      logic ok;
      sb_t e;
      issue(5'd3, 1'b1, 3'b010, 2'd0, ok);
      sb.push_back('{rd: 5'd3, data: 32'h22, exp: 32'h22});
      e = sb.pop_front();
      alu_we = 1'b1; alu_rd = 5'd3; alu_wdata = 32'h11;
      ld_valid = 1'b1; ld_data = e.data;
      #1;
      checks++;
      if ({ok, ld_ready} !== 2'b10) begin
         failures++;
         $display("FAIL collide_ready got ok=%b ld_ready=%b want 1 0", ok, ld_ready);
      end
      step();
      alu_we = 1'b0; ld_valid = 1'b0; rs1_addr = 5'd3;
      #1;
      checks++;
      if ({rs1_data, lq_count} !== {32'h11, 3'd1}) begin
         failures++;
         $display("FAIL collide_alu got x3=%h count=%0d want 11 1", rs1_data, lq_count);
      end
      ld_valid = 1'b1;
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL collide_retry got ld_ready=%b want 1", ld_ready);
      end
      step();
      ld_valid = 1'b0;
      #1;
      checks++;
      if ({rs1_data, lq_count} !== {e.exp, 3'd0}) begin
         failures++;
         $display("FAIL collide_load got x3=%h count=%0d want %h 0", rs1_data, lq_count, e.exp);
      end
   endtask

   task automatic test_bypass();
      logic ok;
      logic [XLEN-1:0] exp_d;
      logic exp_b;
      alu_we = 1'b1; alu_rd = 5'd7; alu_wdata = 32'h33;
      step();
      alu_we = 1'b0;
      issue(5'd7, 1'b0, 3'b000, 2'd0, ok);
      rs1_addr = 5'd7;
      alu_we = 1'b1; alu_rd = 5'd7; alu_wdata = 32'h55;
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      exp_d = 32'h55; exp_b = 1'b0;
`else
      exp_d = 32'h33; exp_b = 1'b1;
`endif
      checks++;
      if ({ok, rs1_data, rs1_busy} !== {1'b1, exp_d, exp_b}) begin
         failures++;
         $display("FAIL bypass_same got ok=%b x7=%h busy=%b want 1 %h %b", ok, rs1_data, rs1_busy, exp_d, exp_b);
      end
      step();
      alu_rd = 5'd0; alu_wdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({rs1_data, rs1_busy} !== {32'h55, 1'b0}) begin
         failures++;
         $display("FAIL bypass_next got x7=%h busy=%b want 55 0", rs1_data, rs1_busy);
      end
      step();
      alu_we = 1'b0; rs2_addr = 5'd0;
      #1;
      checks++;
      if (rs2_data !== 32'h0) begin
         failures++;
         $display("FAIL x0_write got x0=%h want 0", rs2_data);
      end
   endtask

   task automatic test_reset_flush();
      logic ok;
      issue(5'd22, 1'b1, 3'b010, 2'd0, ok);
      rs1_addr = 5'd22;
      #1;
      checks++;
      if ({ok, rs1_busy, lq_count} !== {1'b1, 1'b1, 3'd1}) begin
         failures++;
         $display("FAIL flush_pre got ok=%b busy=%b count=%0d want 1 1 1", ok, rs1_busy, lq_count);
      end
      reset = 1'b1; ld_valid = 1'b1; ld_data = 32'h7777_7777; rs2_addr = 5'd7;
      #1;
      checks++;
      if ({lq_count, rs1_busy, ld_ready, rs2_data} !== {3'd0, 1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL flush_async got count=%0d busy=%b ld_ready=%b x7=%h want 0 0 0 0", lq_count, rs1_busy, ld_ready, rs2_data);
      end
      sb.delete();
      step();
      reset = 1'b0;
      step();
      ld_valid = 1'b0;
      #1;
      checks++;
      if ({lq_count, issue_ready} !== {3'd0, 1'b1}) begin
         failures++;
         $display("FAIL flush_post got count=%0d issue_ready=%b want 0 1", lq_count, issue_ready);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      test_reset();
      step();
      test_lb();
      test_lhu_busy();
      step();
      test_fill();
      test_back_to_back();
      test_collision();
      test_bypass();
      test_reset_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
